// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer controller: display-mode codes,
// controller states and the delay LFSR definition.
package rt_pkg;

    localparam int MS_W     = 11;
    localparam int MS_LIMIT = (1 << MS_W) - 1;

    localparam logic [1:0] SEL_CLEAR      = 2'b00;
    localparam logic [1:0] SEL_STOP_EARLY = 2'b01;
    localparam logic [1:0] SEL_START      = 2'b10;
    localparam logic [1:0] SEL_COUNT      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        COUNT,
        EARLY,
        DONE
    } state_t;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            IDLE:    return SEL_CLEAR;
            WAIT:    return SEL_START;
            COUNT:   return SEL_COUNT;
            EARLY:   return SEL_STOP_EARLY;
            DONE:    return SEL_COUNT;
            default: return SEL_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: pulses tick once every TICK_DIV enabled clocks.
// Dropping en clears the count, so re-enabling always starts a full period.
module ms_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer control FSM: random wait after start, then counts milliseconds
// until stop (or saturation) and presents mode/value to the seven-segment driver.
module reaction_timer_ctrl
    import rt_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_DIV     = CLK_HZ / 1000,
    parameter int MIN_DELAY_MS = 2000,
    parameter int DELAY_BITS   = 13,
    parameter int MAX_MS       = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_btn,
    input  logic            stop_btn,
    input  logic            clear_btn,
    output logic [1:0]      sel,
    output logic [MS_W-1:0] ms,
    output logic            led,
    output logic            done
);

    // One spare bit of headroom above the largest possible delay.
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << DELAY_BITS)) + 1;
    localparam logic [MS_W-1:0] MAX_MS_V = MS_W'(MAX_MS);

    if (MAX_MS < 1 || MAX_MS > MS_LIMIT) begin : g_bad_max_ms
        $error("reaction_timer_ctrl: MAX_MS must be in 1..2047");
    end
    if (DELAY_BITS < 1 || DELAY_BITS > 16) begin : g_bad_delay_bits
        $error("reaction_timer_ctrl: DELAY_BITS must be in 1..16");
    end
    if (MIN_DELAY_MS < 1) begin : g_bad_min_delay
        $error("reaction_timer_ctrl: MIN_DELAY_MS must be at least 1");
    end
    if (TICK_DIV < 1 || TICK_DIV > CLK_HZ) begin : g_bad_tick_div
        $error("reaction_timer_ctrl: TICK_DIV must be in 1..CLK_HZ");
    end

    state_t           state_q, state_d;
    logic [2:0]       btn_q, btn_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [1:0]       sel_q, sel_d;
    logic             led_q, led_d;
    logic             done_q, done_d;

    logic start_e, stop_e, clear_e;
    logic launch;
    logic tick_en, tick;

    // The prescaler is idle outside WAIT/COUNT, and the WAIT->COUNT hand-off
    // happens on a wrap, so both states start from a cleared prescaler.
    assign tick_en = (state_q == WAIT) || (state_q == COUNT);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        btn_d   = {start_btn, stop_btn, clear_btn};
        start_e = start_btn & ~btn_q[2];
        stop_e  = stop_btn  & ~btn_q[1];
        clear_e = clear_btn & ~btn_q[0];
        lfsr_d  = lfsr_next(lfsr_q);

        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        delay_d   = delay_q;
        ms_d      = ms_q;
        launch    = 1'b0;

        if (clear_e) begin
            state_d = IDLE;
            ms_d    = '0;
        end else begin
            case (state_q)
                IDLE: launch = start_e;
                WAIT: begin
                    if (stop_e) begin
                        state_d = EARLY;
                        ms_d    = '0;
                    end else if (tick) begin
                        if (dly_cnt_q + 1'b1 == delay_q) begin
                            state_d = COUNT;
                            ms_d    = '0;
                        end else begin
                            dly_cnt_d = dly_cnt_q + 1'b1;
                        end
                    end
                end
                COUNT: begin
                    // A stop in the same cycle as a tick freezes the pre-tick value.
                    if (stop_e) begin
                        state_d = DONE;
                    end else if (tick) begin
                        if (ms_q + 1'b1 == MAX_MS_V) begin
                            state_d = DONE;
                            ms_d    = MAX_MS_V;
                        end else begin
                            ms_d = ms_q + 1'b1;
                        end
                    end
                end
                EARLY, DONE: launch = start_e;
                default: begin
                    state_d = IDLE;
                    ms_d    = '0;
                end
            endcase
        end

        if (launch) begin
            state_d   = WAIT;
            dly_cnt_d = '0;
            delay_d   = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[DELAY_BITS-1:0]);
            ms_d      = '0;
        end

        sel_d  = sel_of(state_d);
        led_d  = (state_d == COUNT);
        done_d = (state_d == EARLY) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            btn_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            dly_cnt_q <= '0;
            delay_q   <= '0;
            ms_q      <= '0;
            sel_q     <= SEL_CLEAR;
            led_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn_d;
            lfsr_q    <= lfsr_d;
            dly_cnt_q <= dly_cnt_d;
            delay_q   <= delay_d;
            ms_q      <= ms_d;
            sel_q     <= sel_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

    assign sel  = sel_q;
    assign ms   = ms_q;
    assign led  = led_q;
    assign done = done_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: a phase/elapsed-cycle model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reaction_timer_ctrl;

    localparam int TD    = 4;
    localparam int MIN_D = 3;
    localparam int DB    = 2;
    localparam int MAXMS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic        clear_btn = 1'b0;
    logic [1:0]  sel;
    logic [10:0] ms;
    logic        led;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    reaction_timer_ctrl #(
        .CLK_HZ       (100_000_000),
        .TICK_DIV     (TD),
        .MIN_DELAY_MS (MIN_D),
        .DELAY_BITS   (DB),
        .MAX_MS       (MAXMS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .clear_btn (clear_btn),
        .sel       (sel),
        .ms        (ms),
        .led       (led),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_WAIT = 1, P_COUNT = 2, P_EARLY = 3, P_DONE = 4;
    int          ph, cyc, m_dly, res;
    logic [15:0] m_lfsr;
    bit          ps, pt, pc, se, te, ce, launch;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = P_IDLE; cyc = 0; m_dly = 0; res = 0;
            m_lfsr = 16'hACE1; ps = 0; pt = 0; pc = 0;
        end else begin
            se = start_btn && !ps;
            te = stop_btn && !pt;
            ce = clear_btn && !pc;
            launch = 0;
            if (ce) ph = P_IDLE;
            else begin
                case (ph)
                    P_WAIT: begin
                        if (te) ph = P_EARLY;
                        else if (cyc + 1 == m_dly * TD) begin ph = P_COUNT; cyc = 0; end
                        else cyc++;
                    end
                    P_COUNT: begin
                        if (te) begin ph = P_DONE; res = cyc / TD; end
                        else if (cyc + 1 == MAXMS * TD) begin ph = P_DONE; res = MAXMS; end
                        else cyc++;
                    end
                    default: launch = se;
                endcase
            end
            if (launch) begin
                ph = P_WAIT; cyc = 0;
                m_dly = MIN_D + (int'(m_lfsr) % (1 << DB));
            end
            m_lfsr = lfsr_step(m_lfsr);
            ps = start_btn; pt = stop_btn; pc = clear_btn;
        end
    end

    function automatic int exp_sel();
        case (ph)
            P_WAIT:  return 2;
            P_COUNT: return 3;
            P_EARLY: return 1;
            P_DONE:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_ms();
        if (ph == P_COUNT) return cyc / TD;
        if (ph == P_DONE)  return res;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_sel", int'(sel), exp_sel());
            chk("model_ms", int'(ms), exp_ms());
            chk("model_led", int'(led), int'(ph == P_COUNT));
            chk("model_done", int'(done), int'(ph == P_EARLY || ph == P_DONE));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input bit s, input bit t, input bit c);
        start_btn = s; stop_btn = t; clear_btn = c;
        @(negedge clk);
        start_btn = 0; stop_btn = 0; clear_btn = 0;
    endtask

    task automatic wait_led(input int maxc, input string nm);
        int n;
        n = 0;
        while (led !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(led === 1'b1), 1);
    endtask

    task automatic chk_out(input string nm, input int s, input int m, input int l, input int d);
        chk({nm, "_sel"}, int'(sel), s);
        chk({nm, "_ms"}, int'(ms), m);
        chk({nm, "_led"}, int'(led), l);
        chk({nm, "_done"}, int'(done), d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, entries, prev;
        bit led_seen;

        repeat (3) @(negedge clk);
        chk_out("reset", 0, 0, 0, 0);
        chk_en = 1;
        rst_n = 1;
        repeat (20) @(negedge clk);
        chk_out("idle", 0, 0, 0, 0);

        // start, then stop 3 ms after the lamp lights
        pulse(1, 0, 0);
        chk("wait_entry_sel", int'(sel), 2);
        n = 0;
        while (sel == 2'b10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_len", n, m_dly * TD);
        chk("wait_len_range", int'(n >= MIN_D * TD && n <= (MIN_D + 3) * TD), 1);
        chk("count_led", int'(led), 1);
        chk("count_sel", int'(sel), 3);
        repeat (12) @(negedge clk);
        pulse(0, 1, 0);
        chk_out("stop3", 3, 3, 0, 1);
        repeat (20) @(negedge clk);
        chk("stop3_held_ms", int'(ms), 3);

        // start from DONE restarts; stop coinciding with a tick drops it
        pulse(1, 0, 0);
        chk_out("restart", 2, 0, 0, 0);
        wait_led(40, "restart_led_timeout");
        repeat (11) @(negedge clk);
        pulse(0, 1, 0);
        chk_out("stop_on_tick", 3, 2, 0, 1);

        // early stop during WAIT
        pulse(1, 0, 0);
        led_seen = 0;
        repeat (5) begin
            if (led) led_seen = 1;
            @(negedge clk);
        end
        pulse(0, 1, 0);
        repeat (10) begin
            if (led) led_seen = 1;
            @(negedge clk);
        end
        chk_out("early", 1, 0, 0, 1);
        chk("early_led_seen", int'(led_seen), 0);

        // clear, then let the count saturate
        pulse(0, 0, 1);
        chk_out("clear", 0, 0, 0, 0);
        pulse(1, 0, 0);
        wait_led(40, "timeout_led_timeout");
        repeat (45) @(negedge clk);
        chk_out("timeout", 3, 10, 0, 1);
        repeat (80) @(negedge clk);
        chk("timeout_no_wrap_ms", int'(ms), 10);

        // start, stop and clear together from DONE: clear wins
        pulse(1, 1, 1);
        chk_out("all_three", 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_out("all_three_hold", 0, 0, 0, 0);

        // start held high: single WAIT entry
        entries = 0;
        prev = int'(sel);
        start_btn = 1;
        repeat (50) begin
            @(negedge clk);
            if (sel == 2'b10 && prev != 2) entries++;
            prev = int'(sel);
        end
        start_btn = 0;
        chk("held_start_entries", entries, 1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("held_done_reached", int'(done === 1'b1), 1);
        pulse(1, 0, 0);
        chk_out("done_restart", 2, 0, 0, 0);

        // asynchronous reset in the middle of COUNT
        wait_led(40, "rst_led_timeout");
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1 chk_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk_out("post_rst", 0, 0, 0, 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Control FSM for the reaction-timer lab.
- Takes the debounced start/stop/clear buttons, waits a pseudo-random delay, lights the stimulus LED, then counts milliseconds until the user presses stop.
- Drives the 2-bit display-mode select (clear / stop_early / start / count) and the 11-bit millisecond value consumed by the seven-segment display driver.
- Sits between the button debouncers and the display driver.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_DIV, CLK_HZ/1000, clocks per 1 ms tick.
- MIN_DELAY_MS, 2000, minimum wait before the LED lights.
- DELAY_BITS, 13, LFSR bits added to MIN_DELAY_MS (random span 0..2^DELAY_BITS-1 ms).
- MAX_MS, 1000, reaction timeout; ms saturates here.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_btn  in  1  debounced start button, level, active-high.
- stop_btn  in  1  debounced stop button, level, active-high.
- clear_btn  in  1  debounced clear button, level, active-high.
- sel  out  2  display mode: 00 clear, 01 stop_early, 10 start, 11 count.
- ms  out  11  reaction time in ms, binary 0..MAX_MS.
- led  out  1  stimulus lamp, high while counting.
- done  out  1  high once a result (stop or timeout) is held.

Behaviour:
- Reset (rst_n low, async): state=IDLE, sel=00, ms=0, led=0, done=0, all counters 0, LFSR=16'hACE1, edge registers=0. Applies immediately, including mid-operation.
- Buttons: rising-edge detected internally (1 flop per button). An edge is seen the cycle after the input rises; holding a button does not retrigger.
- Priority of same-cycle edges: clear > stop > start.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clock and never reaches zero.
- ms tick: prescaler counts 0..TICK_DIV-1 and pulses tick on wrap. Runs only in WAIT and COUNT, and is cleared on entry to each.
- States:
  - IDLE: sel=00, led=0, done=0, ms=0. A start edge latches delay_ms = MIN_DELAY_MS + lfsr[DELAY_BITS-1:0] and moves to WAIT.
  - WAIT: sel=10, led=0. The delay counter increments per tick; when it equals delay_ms -> COUNT, with ms=0. A stop edge -> EARLY. A start edge is ignored.
  - COUNT: sel=11, led=1. ms increments per tick. A stop edge -> DONE with ms frozen at its current value (the tick and the stop in the same cycle: the tick is dropped). ms reaching MAX_MS -> DONE with ms=MAX_MS, no wrap.
  - EARLY: sel=01, led=0, ms=0, done=1.
  - DONE: sel=11, led=0, ms held, done=1.
- Clear edge: returns any state to IDLE next cycle.
- Start edge in EARLY or DONE: behaves as clear followed by start, i.e. goes directly to WAIT with a fresh delay and ms=0, done=0.
- Outputs are registered; sel, led and done change on the same clock edge as the state.
- Widths: the delay counter is wide enough for MIN_DELAY_MS + 2^DELAY_BITS-1 (15 bits at defaults). ms is 11 bits; MAX_MS must be at most 2047, checked by an elaboration assertion.

Decomposition:
- Package rt_pkg:
  - sel codes SEL_CLEAR=2'b00, SEL_STOP_EARLY=2'b01, SEL_START=2'b10, SEL_COUNT=2'b11.
  - typedef enum state_t {IDLE, WAIT, COUNT, EARLY, DONE}.
  - LFSR seed and tap constants.
- One sub-module: ms_tick_gen (parameter TICK_DIV; ports clk, rst_n, en, tick), shared with future stopwatch blocks.
- Edge detect and LFSR stay inline.

Test Plan (bench parameters TICK_DIV=4, MIN_DELAY_MS=3, DELAY_BITS=2, MAX_MS=10):
- Reset, then idle 20 cycles -> sel=00, ms=0, led=0, done=0 throughout. Assert rst_n low mid-COUNT -> all outputs at reset values within the same cycle.
- Start pulse, then stop 3 ms after led rises -> WAIT lasts (3 + lfsr[1:0]) ms with sel=10; led=1 and sel=11 in COUNT; after stop, ms=3, done=1, sel=11, led=0, and the value is held.
- Stop pulse during WAIT -> sel=01, ms=0, done=1, led never asserted.
- No stop after led rises -> ms counts 0..10, saturates at 10, done=1, led=0, no wrap after another 20 ticks.
- Start, stop and clear asserted in the same cycle from DONE -> state IDLE, sel=00, ms=0, done=0.
- Start held high for 50 cycles from IDLE -> exactly one WAIT entry. Start edge from DONE -> WAIT with ms=0, done=0.
